// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern generator: pattern modes and bounce direction.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_BLINK  = 2'd0,
    MODE_ROL    = 2'd1,
    MODE_ROR    = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/led_pattern_gen_if.sv
// Control/status bundle between a switch/register block (master) and the LED pattern generator (slave).
interface led_pattern_gen_if #(
  parameter int unsigned LED_NUM = 4
);
  logic               en;
  logic [1:0]         mode;
  logic [1:0]         speed;
  logic [LED_NUM-1:0] led;
  logic               tick;

  modport master (output en, mode, speed, input led, tick);
  modport slave  (input en, mode, speed, output led, tick);
endinterface

// File: rtl/led_tick_gen.sv
// Programmable-period step strobe; period is TICK_CYCLES >> speed, held while paused.
module led_tick_gen #(
  parameter int unsigned TICK_CYCLES = 25_000_000,
  parameter int unsigned CNT_W       = $clog2(TICK_CYCLES)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] speed,
  input  logic       clr,
  output logic       tick_int
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lim;

  // Terminal count is formed before truncation so a power-of-two TICK_CYCLES still fits CNT_W.
  always_comb lim = CNT_W'((TICK_CYCLES >> speed) - 32'd1);

  // >= so that shortening the period mid-count fires at once instead of wrapping the counter.
  assign tick_int = en && (cnt_q >= lim);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = tick_int ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-LED pattern generator: blink, rotate-left, rotate-right or bounce, stepped by led_tick_gen.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int unsigned LED_NUM     = 4,
  parameter int unsigned TICK_CYCLES = 25_000_000,
  parameter int unsigned CNT_W       = $clog2(TICK_CYCLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  led_pattern_gen_if.slave bus
);

  localparam logic [LED_NUM-1:0] SEED_LO = LED_NUM'(1);
  localparam logic [LED_NUM-1:0] SEED_HI = SEED_LO << (LED_NUM - 1);

  mode_e              mode_q, mode_d, mode_in;
  dir_e               dir_q, dir_d;
  logic [LED_NUM-1:0] led_q, led_d;
  logic               tick_q, tick_d;
  logic [LED_NUM-1:0] rol, ror;
  logic               mode_chg;
  logic               tick_int;

  assign mode_in  = mode_e'(bus.mode);
  assign mode_chg = (mode_in != mode_q);

  led_tick_gen #(
    .TICK_CYCLES (TICK_CYCLES),
    .CNT_W       (CNT_W)
  ) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (bus.en),
    .speed    (bus.speed),
    .clr      (mode_chg),
    .tick_int (tick_int)
  );

  generate
    if (LED_NUM > 1) begin : g_shift
      assign rol = {led_q[LED_NUM-2:0], led_q[LED_NUM-1]};
      assign ror = {led_q[0], led_q[LED_NUM-1:1]};
    end else begin : g_hold
      assign rol = led_q;
      assign ror = led_q;
    end
  endgenerate

  always_comb begin
    mode_d = mode_q;
    dir_d  = dir_q;
    led_d  = led_q;
    tick_d = 1'b0;
    // A mode change reseeds and discards any step due in the same cycle.
    if (mode_chg) begin
      mode_d = mode_in;
      dir_d  = DIR_UP;
      unique case (mode_in)
        MODE_BLINK: led_d = '1;
        MODE_ROR:   led_d = SEED_HI;
        default:    led_d = SEED_LO;
      endcase
    end else if (tick_int) begin
      tick_d = 1'b1;
      unique case (mode_q)
        MODE_BLINK: led_d = ~led_q;
        MODE_ROL:   led_d = rol;
        MODE_ROR:   led_d = ror;
        MODE_BOUNCE: begin
          if (dir_q == DIR_UP) begin
            led_d = rol;
            if (rol[LED_NUM-1]) dir_d = DIR_DOWN;
          end else begin
            led_d = ror;
            if (ror[0]) dir_d = DIR_UP;
          end
        end
        default: led_d = led_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_BLINK;
      dir_q  <= DIR_UP;
      led_q  <= '1;
      tick_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      dir_q  <= dir_d;
      led_q  <= led_d;
      tick_q <= tick_d;
    end
  end

  assign bus.led  = led_q;
  assign bus.tick = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with LED_NUM = 4, TICK_CYCLES = 8.
module tb_led_pattern_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  led_pattern_gen_if #(.LED_NUM(4)) bus ();

  led_pattern_gen #(
    .LED_NUM     (4),
    .TICK_CYCLES (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic [1:0] m, input logic [1:0] s);
    rst_n     = 1'b0;
    bus.en    = 1'b1;
    bus.mode  = m;
    bus.speed = s;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int ticks;
    apply_reset(2'd0, 2'd0);
    checks++;
    if (bus.led !== 4'b1111 || bus.tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: led=%b tick=%b expected led=1111 tick=0", bus.led, bus.tick);
    end
    step(7);
    checks++;
    if (bus.led !== 4'b1111 || bus.tick !== 1'b0) begin
      errors++;
      $display("FAIL blink_pre_tick: led=%b tick=%b expected led=1111 tick=0", bus.led, bus.tick);
    end
    step(1);
    checks++;
    if (bus.led !== 4'b0000 || bus.tick !== 1'b1) begin
      errors++;
      $display("FAIL blink_cycle8: led=%b tick=%b expected led=0000 tick=1", bus.led, bus.tick);
    end
    step(8);
    checks++;
    if (bus.led !== 4'b1111 || bus.tick !== 1'b1) begin
      errors++;
      $display("FAIL blink_cycle16: led=%b tick=%b expected led=1111 tick=1", bus.led, bus.tick);
    end
    ticks = 0;
    for (int i = 0; i < 32; i++) begin
      step(1);
      if (bus.tick === 1'b1) ticks++;
    end
    checks++;
    if (ticks !== 4) begin
      errors++;
      $display("FAIL blink_tick_rate: ticks=%0d in 32 cycles expected 4", ticks);
    end
  endtask

  task automatic test_rotate();
    logic [3:0] rl [4];
    logic [3:0] rr [4];
    rl = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
    apply_reset(2'd1, 2'd0);
    step(1);
    checks++;
    if (bus.led !== 4'b0001 || bus.tick !== 1'b0) begin
      errors++;
      $display("FAIL rol_seed: led=%b tick=%b expected led=0001 tick=0", bus.led, bus.tick);
    end
    for (int i = 0; i < 4; i++) begin
      step(8);
      checks++;
      if (bus.led !== rl[i] || bus.tick !== 1'b1) begin
        errors++;
        $display("FAIL rol_step%0d: led=%b tick=%b expected led=%b tick=1", i, bus.led, bus.tick, rl[i]);
      end
    end
    bus.mode = 2'd2;
    step(1);
    checks++;
    if (bus.led !== 4'b1000 || bus.tick !== 1'b0) begin
      errors++;
      $display("FAIL ror_seed: led=%b tick=%b expected led=1000 tick=0", bus.led, bus.tick);
    end
    for (int i = 0; i < 4; i++) begin
      step(8);
      checks++;
      if (bus.led !== rr[i] || bus.tick !== 1'b1) begin
        errors++;
        $display("FAIL ror_step%0d: led=%b tick=%b expected led=%b tick=1", i, bus.led, bus.tick, rr[i]);
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] bs [8];
    bs = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};
    apply_reset(2'd3, 2'd0);
    step(1);
    checks++;
    if (bus.led !== 4'b0001) begin
      errors++;
      $display("FAIL bounce_seed: led=%b expected 0001", bus.led);
    end
    for (int i = 0; i < 8; i++) begin
      step(8);
      checks++;
      if (bus.led !== bs[i] || bus.tick !== 1'b1) begin
        errors++;
        $display("FAIL bounce_step%0d: led=%b tick=%b expected led=%b tick=1", i, bus.led, bus.tick, bs[i]);
      end
    end
  endtask

  task automatic test_speed();
    logic [3:0] exp_led;
    apply_reset(2'd0, 2'd3);
    exp_led = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step(1);
      exp_led = ~exp_led;
      checks++;
      if (bus.led !== exp_led || bus.tick !== 1'b1) begin
        errors++;
        $display("FAIL speed3_%0d: led=%b tick=%b expected led=%b tick=1", i, bus.led, bus.tick, exp_led);
      end
    end
    bus.speed = 2'd2;
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++;
      if (bus.tick !== 1'b0) begin
        errors++;
        $display("FAIL speed2_gap%0d: tick=%b expected 0", i, bus.tick);
      end
      step(1);
      exp_led = ~exp_led;
      checks++;
      if (bus.led !== exp_led || bus.tick !== 1'b1) begin
        errors++;
        $display("FAIL speed2_tick%0d: led=%b tick=%b expected led=%b tick=1", i, bus.led, bus.tick, exp_led);
      end
    end
    apply_reset(2'd0, 2'd0);
    step(5);
    bus.speed = 2'd2;
    step(1);
    checks++;
    if (bus.led !== 4'b0000 || bus.tick !== 1'b1) begin
      errors++;
      $display("FAIL speedup_overshoot: led=%b tick=%b expected led=0000 tick=1", bus.led, bus.tick);
    end
    step(1);
    checks++;
    if (bus.tick !== 1'b0) begin
      errors++;
      $display("FAIL speedup_gap: tick=%b expected 0", bus.tick);
    end
    step(1);
    checks++;
    if (bus.led !== 4'b1111 || bus.tick !== 1'b1) begin
      errors++;
      $display("FAIL speedup_next: led=%b tick=%b expected led=1111 tick=1", bus.led, bus.tick);
    end
  endtask

  task automatic test_pause();
    int bad;
    apply_reset(2'd3, 2'd0);
    step(1);
    step(16);
    step(3);
    checks++;
    if (bus.led !== 4'b0100) begin
      errors++;
      $display("FAIL pause_setup: led=%b expected 0100", bus.led);
    end
    bus.en = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (bus.led !== 4'b0100 || bus.tick !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL pause_hold: %0d cycles changed led/tick expected 0", bad);
    end
    bus.en = 1'b1;
    step(4);
    checks++;
    if (bus.led !== 4'b0100 || bus.tick !== 1'b0) begin
      errors++;
      $display("FAIL resume_early: led=%b tick=%b expected led=0100 tick=0", bus.led, bus.tick);
    end
    step(1);
    checks++;
    if (bus.led !== 4'b1000 || bus.tick !== 1'b1) begin
      errors++;
      $display("FAIL resume_step: led=%b tick=%b expected led=1000 tick=1", bus.led, bus.tick);
    end
    step(8);
    checks++;
    if (bus.led !== 4'b0100) begin
      errors++;
      $display("FAIL resume_dir: led=%b expected 0100", bus.led);
    end
  endtask

  task automatic test_mode_vs_tick();
    apply_reset(2'd0, 2'd0);
    step(7);
    bus.mode = 2'd1;
    step(1);
    checks++;
    if (bus.led !== 4'b0001 || bus.tick !== 1'b0) begin
      errors++;
      $display("FAIL modechg_tick: led=%b tick=%b expected led=0001 tick=0", bus.led, bus.tick);
    end
    step(7);
    checks++;
    if (bus.led !== 4'b0001 || bus.tick !== 1'b0) begin
      errors++;
      $display("FAIL modechg_wait: led=%b tick=%b expected led=0001 tick=0", bus.led, bus.tick);
    end
    step(1);
    checks++;
    if (bus.led !== 4'b0010 || bus.tick !== 1'b1) begin
      errors++;
      $display("FAIL modechg_step: led=%b tick=%b expected led=0010 tick=1", bus.led, bus.tick);
    end
  endtask

  task automatic test_async_reset();
    apply_reset(2'd3, 2'd0);
    step(1);
    step(32);
    step(3);
    checks++;
    if (bus.led !== 4'b0100) begin
      errors++;
      $display("FAIL areset_setup: led=%b expected 0100", bus.led);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.led !== 4'b1111 || bus.tick !== 1'b0) begin
      errors++;
      $display("FAIL areset_immediate: led=%b tick=%b expected led=1111 tick=0", bus.led, bus.tick);
    end
    step(2);
    checks++;
    if (bus.led !== 4'b1111) begin
      errors++;
      $display("FAIL areset_hold: led=%b expected 1111", bus.led);
    end
    rst_n = 1'b1;
    step(1);
    checks++;
    if (bus.led !== 4'b0001) begin
      errors++;
      $display("FAIL areset_reseed: led=%b expected 0001", bus.led);
    end
    step(8);
    checks++;
    if (bus.led !== 4'b0010 || bus.tick !== 1'b1) begin
      errors++;
      $display("FAIL areset_dir_up: led=%b tick=%b expected led=0010 tick=1", bus.led, bus.tick);
    end
  endtask

  initial begin
    bus.en    = 1'b1;
    bus.mode  = 2'd0;
    bus.speed = 2'd0;
    test_reset();
    test_rotate();
    test_bounce();
    test_speed();
    test_pause();
    test_mode_vs_tick();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
